// File: rtl/game_pkg.sv
// Shared types and default timing constants for the Flappy Bird game blocks.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDying,
    StOver
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned DefTicksPerPoint = 17;
  localparam int unsigned DefDeathFrames   = 8;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD incrementer with synchronous clear; saturates at all nines.
module bcd_counter
  import game_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                inc,
  output logic [4*DIGITS-1:0] value
);

  bcd_digit_t [DIGITS-1:0] digit_q, digit_d;
  logic                    all_nines;
  logic                    carry;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q[i] != 4'd9) all_nines = 1'b0;
    end
  end

  // Ripple the +1 through the digits; a non-9 digit absorbs the carry.
  always_comb begin
    digit_d = digit_q;
    carry   = inc && !all_nines;
    if (clear) begin
      digit_d = '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (digit_q[i] == 4'd9) begin
            digit_d[i] = 4'd0;
          end else begin
            digit_d[i] = digit_q[i] + 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign value = digit_q;

endmodule

// File: rtl/game_controller.sv
// Play sequencer: game flow FSM, frame-tick scoring cadence, dying delay and high score.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT = DefTicksPerPoint,
  parameter int unsigned DEATH_FRAMES    = DefDeathFrames,
  parameter int unsigned DIGITS          = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                frameTick,
  input  logic                collide,
  output logic                Stop,
  output logic                playing,
  output logic                gameOver,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] highScore,
  output logic                newHigh
);

  localparam int unsigned TickW  = $clog2(TICKS_PER_POINT);
  localparam int unsigned DeathW = $clog2(DEATH_FRAMES + 1);

  game_state_t         state_q, state_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [DeathW-1:0]   death_q, death_d;
  logic [4*DIGITS-1:0] high_q, high_d;
  logic                new_high_q, new_high_d;
  logic                score_clear;
  logic                score_inc;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    death_d     = death_q;
    high_d      = high_q;
    new_high_d  = new_high_q;
    score_clear = 1'b0;
    score_inc   = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d     = StPlay;
          tick_d      = '0;
          new_high_d  = 1'b0;
          score_clear = 1'b1;
        end
      end
      StPlay: begin
        // A collision on a scoring tick wins; no point is awarded.
        if (collide) begin
          state_d = StDying;
          death_d = '0;
        end else if (frameTick) begin
          if (tick_q == TickW'(TICKS_PER_POINT - 1)) begin
            tick_d    = '0;
            score_inc = 1'b1;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      StDying: begin
        if (frameTick) begin
          death_d = death_q + DeathW'(1);
          if (death_q == DeathW'(DEATH_FRAMES - 1)) begin
            state_d = StOver;
            // Packed BCD compares correctly as a plain unsigned vector.
            if (score > high_q) begin
              high_d     = score;
              new_high_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      death_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      death_q    <= death_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  bcd_counter #(
    .DIGITS(DIGITS)
  ) u_score (
    .clk  (clk),
    .reset(reset),
    .clear(score_clear),
    .inc  (score_inc),
    .value(score)
  );

  always_comb begin
    Stop     = (state_q != StPlay);
    playing  = (state_q == StPlay);
    gameOver = (state_q == StOver);
  end

  assign highScore = high_q;
  assign newHigh   = new_high_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: integer reference model, per-cycle expectations.
module tb_game_controller;

  localparam int TPP    = 17;
  localparam int DF     = 8;
  localparam int DIGITS = 3;
  localparam int MAXS   = 999;

  logic        clk = 1'b0;
  logic        reset, start, frameTick, collide;
  logic        Stop, playing, gameOver, newHigh;
  logic [11:0] score, highScore;

  game_controller #(
    .TICKS_PER_POINT(TPP),
    .DEATH_FRAMES   (DF),
    .DIGITS         (DIGITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .frameTick(frameTick),
    .collide  (collide),
    .Stop     (Stop),
    .playing  (playing),
    .gameOver (gameOver),
    .score    (score),
    .highScore(highScore),
    .newHigh  (newHigh)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stop;
    logic        play;
    logic        over;
    logic [11:0] score;
    logic [11:0] high;
    logic        nh;
  } exp_t;

  typedef enum int {MIdle, MPlay, MDying, MOver} mode_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  mode_t m_mode   = MIdle;
  int    m_score  = 0;
  int    m_high   = 0;
  int    m_ticks  = 0;
  int    m_deaths = 0;
  bit    m_nh     = 1'b0;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Apply one cycle of inputs, advance the model, queue what the DUT must show after the edge.
  task automatic step(input bit r, input bit s, input bit f, input bit c);
    exp_t e;
    reset = r; start = s; frameTick = f; collide = c;
    if (!r) begin
      m_mode = MIdle; m_score = 0; m_high = 0; m_ticks = 0; m_deaths = 0; m_nh = 1'b0;
    end else begin
      case (m_mode)
        MIdle, MOver: if (s) begin
          m_mode = MPlay; m_score = 0; m_ticks = 0; m_nh = 1'b0;
        end
        MPlay: begin
          if (c) begin
            m_mode = MDying; m_deaths = 0;
          end else if (f) begin
            m_ticks++;
            if (m_ticks == TPP) begin
              m_ticks = 0;
              if (m_score < MAXS) m_score++;
            end
          end
        end
        MDying: if (f) begin
          m_deaths++;
          if (m_deaths == DF) begin
            m_mode = MOver;
            if (m_score > m_high) begin
              m_high = m_score; m_nh = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    e.stop  = (m_mode != MPlay);
    e.play  = (m_mode == MPlay);
    e.over  = (m_mode == MOver);
    e.score = to_bcd(m_score);
    e.high  = to_bcd(m_high);
    e.nh    = m_nh;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // A frame tick after 0..2 quiet cycles; start noise is only offered while playing.
  task automatic tick(input bit c, input bit start_noise);
    int gap;
    gap = int'($urandom_range(0, 2));
    repeat (gap) step(1'b1, start_noise & 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, start_noise & 1'($urandom_range(0, 1)), 1'b1, c);
  endtask

  task automatic dying_ticks();
    for (int i = 0; i < DF; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {Stop, playing, gameOver, score, highScore, newHigh};
        total++;
        if (got !== e) begin
          bad++;
          if (bad <= 20)
            $display("FAIL outputs @%0t: got stop=%b play=%b over=%b score=%h high=%h nh=%b, required stop=%b play=%b over=%b score=%h high=%h nh=%b",
                     $time, got.stop, got.play, got.over, got.score, got.high, got.nh,
                     e.stop, e.play, e.over, e.score, e.high, e.nh);
        end
      end
    end
  end

  initial begin : driver
    int waitc;
    int n;
    // Reset with a start pulse that must be ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Scoring cadence, then collide on tick 51.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    dying_ticks();
    repeat (3) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Lower replay keeps the old high score.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TPP; i++) tick(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    dying_ticks();
    idle(2);

    // Start together with collide in OVER; collide next cycle goes straight to DYING.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    dying_ticks();
    idle(2);

    // Random short games.
    repeat (6) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n = int'($urandom_range(0, 70));
      repeat (n) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6), 1'b0);
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      dying_ticks();
      idle(int'($urandom_range(1, 3)));
    end

    // Saturation at 999.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (TPP * 1000 + 40) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DF) step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset during DYING discards everything; start during reset ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2 * TPP + 3) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
